level_timer: RTL

- Per-level countdown timer for the game.
- Consumes the one-cycle `one_sec` tick from the slow-clock counter and counts level time down in BCD seconds.
- Drives the BCD digits to the on-screen time display.
- Flags a low-time warning for the HUD blink logic.
- Issues a single `time_up` pulse to the game controller when the level clock runs out.

---
 rtl/level_timer.sv | 114 +++++++++++
 1 files changed

// File: rtl/level_timer.sv
// level_timer: per-level BCD countdown with low-time warning, one-cycle time_up and expiry.
// Optional feature macro TIMER_BONUS_EN: bonus_add adds BONUS_SEC (saturating at 99) in RUN/PAUSED.
module level_timer #(
  parameter int START_SEC = 60,
  parameter int WARN_SEC  = 10,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus_add,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       warning,
  output logic       time_up,
  output logic       expired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  localparam logic [7:0] L_START   = 8'(START_SEC);
  localparam logic [7:0] L_WARN    = 8'(WARN_SEC);
  localparam logic [7:0] L_BONUS   = 8'(BONUS_SEC);
  localparam logic [7:0] L_MAX     = 8'd99;
  localparam logic [3:0] L_START_T = 4'(START_SEC / 10);
  localparam logic [3:0] L_START_O = 4'(START_SEC % 10);

  state_t     r_state, w_nxt_state;
  logic [3:0] r_tens, r_ones;
  logic       r_running, r_warning, r_time_up, r_expired;
  logic [7:0] w_val, w_bonus_amt, w_tick_val, w_add_val, w_nxt_val;
  logic       w_bonus, w_nxt_time_up, w_nxt_warning;

`ifdef TIMER_BONUS_EN
  assign w_bonus = bonus_add;
`else
  logic w_unused_bonus;
  assign w_unused_bonus = bonus_add;
  assign w_bonus        = 1'b0;
`endif

  function automatic logic [7:0] f_sat(input logic [7:0] v);
    return (v > L_MAX) ? L_MAX : v;
  endfunction

  // Arithmetic is done in binary; digits are re-derived from the saturated result.
  assign w_val       = ({4'd0, r_tens} * 8'd10) + {4'd0, r_ones};
  assign w_bonus_amt = w_bonus ? L_BONUS : 8'd0;
  assign w_add_val   = f_sat(w_val + w_bonus_amt);
  assign w_tick_val  = f_sat(((one_sec && (w_val != 8'd0)) ? (w_val - 8'd1) : w_val) + w_bonus_amt);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_val     = w_val;
    w_nxt_time_up = 1'b0;
    if (start) begin
      w_nxt_state = S_RUN;
      w_nxt_val   = L_START;
    end else begin
      case (r_state)
        S_RUN: begin
          if (pause) begin
            w_nxt_state = S_PAUSED;
            w_nxt_val   = w_add_val;
          end else begin
            w_nxt_val = w_tick_val;
            if (one_sec && (w_tick_val == 8'd0)) begin
              w_nxt_state   = S_EXPIRED;
              w_nxt_time_up = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          w_nxt_val = w_add_val;
          if (!pause) w_nxt_state = S_RUN;
        end
        S_EXPIRED: w_nxt_val = 8'd0;
        default:   w_nxt_val = w_val;
      endcase
    end
    w_nxt_warning = ((w_nxt_state == S_RUN) || (w_nxt_state == S_PAUSED)) && (w_nxt_val <= L_WARN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tens    <= L_START_T;
      r_ones    <= L_START_O;
      r_running <= 1'b0;
      r_warning <= 1'b0;
      r_time_up <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_tens    <= 4'(w_nxt_val / 8'd10);
      r_ones    <= 4'(w_nxt_val % 8'd10);
      r_running <= (w_nxt_state == S_RUN);
      r_warning <= w_nxt_warning;
      r_time_up <= w_nxt_time_up;
      r_expired <= (w_nxt_state == S_EXPIRED);
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign running = r_running;
  assign warning = r_warning;
  assign time_up = r_time_up;
  assign expired = r_expired;

endmodule
